// File: rtl/fifo_pop_reader_if.sv
// rtl/fifo_pop_reader_if.sv - FIFO pop side and output stream bundle for fifo_pop_reader
// Counter signals exist only when FIFO_POP_READER_CNT_EN is defined.
interface fifo_pop_reader_if #(
  parameter int bW = 8
);
  logic          en;
  logic          pop;
  logic [bW-1:0] popData;
  logic          empty;
  logic [bW-1:0] outData;
  logic          outValid;
  logic          outReady;
  logic          busy;
`ifdef FIFO_POP_READER_CNT_EN
  logic          clrCnt;
  logic [15:0]   wordCnt;
`endif

  modport master (
    input  en,
    output pop,
    input  popData,
    input  empty,
    output outData,
    output outValid,
    input  outReady,
`ifdef FIFO_POP_READER_CNT_EN
    input  clrCnt,
    output wordCnt,
`endif
    output busy
  );

  modport slave (
    output en,
    input  pop,
    output popData,
    output empty,
    input  outData,
    input  outValid,
    output outReady,
`ifdef FIFO_POP_READER_CNT_EN
    output clrCnt,
    input  wordCnt,
`endif
    input  busy
  );
endinterface

// File: rtl/fifo_pop_reader.sv
// rtl/fifo_pop_reader.sv - FIFO drain master with 2-entry skid buffer onto a valid/ready stream
// Optional delivered-word counter enabled by FIFO_POP_READER_CNT_EN.
module fifo_pop_reader #(
  parameter int bW = 8
) (
  input  logic                clk,
  input  logic                rst,
  fifo_pop_reader_if.master   bus
);

  logic [bW-1:0] r_buf [0:1];
  logic          r_wp;
  logic          r_rp;
  logic [1:0]    r_occ;
  logic          r_inflight;

  logic          w_deq;
  logic          w_pop;
  logic [2:0]    w_level;

  assign w_deq   = bus.outValid && bus.outReady;
  // Slots committed after this cycle's dequeue; popping only below 2 keeps the buffer from overflowing.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_deq};
  assign w_pop   = rst && bus.en && !bus.empty && (w_level < 3'd2);

  assign bus.pop      = w_pop;
  assign bus.outValid = (r_occ != 2'd0);
  assign bus.outData  = r_buf[r_rp];
  assign bus.busy     = (r_occ != 2'd0) || r_inflight;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_pop;
      if (r_inflight) begin
        r_buf[r_wp] <= bus.popData;
        r_wp        <= ~r_wp;
      end
      if (w_deq) begin
        r_rp <= ~r_rp;
      end
      case ({r_inflight, w_deq})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef FIFO_POP_READER_CNT_EN
  logic [15:0] r_word_cnt;

  assign bus.wordCnt = r_word_cnt;

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word_cnt <= 16'd0;
    end else if (bus.clrCnt) begin
      r_word_cnt <= 16'd0;
    end else if (w_deq) begin
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_pop_reader.sv
// tb/tb_fifo_pop_reader.sv - scoreboard bench for fifo_pop_reader
// Counter checks compile in when FIFO_POP_READER_CNT_EN is defined.
module tb_fifo_pop_reader;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_pop_reader_if #(.bW(BW)) bus ();
  fifo_pop_reader #(.bW(BW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  logic [BW-1:0] fq[$];
  logic [BW-1:0] exp_q[$];
  logic force_empty = 1'b0;
  logic pend = 1'b0;
  int cyc = 0;
  int pop_cnt = 0;
  int deq_cnt = 0;
  int first_pop = -1;
  int first_out = -1;
  int last_out  = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic set_empty();
    bus.empty = (fq.size() == 0) || force_empty;
  endtask

  task automatic load(input logic [BW-1:0] w, input bit expect_out);
    fq.push_back(w);
    if (expect_out) exp_q.push_back(w);
    set_empty();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.busy || fq.size() != 0) && k < bound) begin
      @(negedge clk);
      k++;
    end
    check({name, "_drain_timeout"}, (k >= bound) ? 32'd1 : 32'd0, 32'd0);
  endtask

  always @(posedge clk) cyc++;

  // FIFO model: pop sampled mid-cycle, data presented just after the following edge.
  always @(negedge clk) begin
    pend = bus.pop;
    if (bus.pop) begin
      pop_cnt++;
      if (first_pop < 0) first_pop = cyc;
    end
    if (rst && bus.empty) check("no_pop_when_empty", {31'd0, bus.pop}, 32'd0);
  end

  always @(posedge clk) begin
    #1;
    if (pend) begin
      if (fq.size() > 0) bus.popData = fq.pop_front();
      set_empty();
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst && bus.outValid && bus.outReady) begin
      deq_cnt++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      if (exp_q.size() == 0) check("sb_unexpected_word", {24'd0, bus.outData}, 32'hFFFF_FFFF);
      else check("sb_data", {24'd0, bus.outData}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int c0, p0, d0;
    bus.en = 1'b1;
    bus.outReady = 1'b1;
    bus.popData = '0;
`ifdef FIFO_POP_READER_CNT_EN
    bus.clrCnt = 1'b0;
`endif
    load(8'h77, 1'b0);

    // Reset holds everything quiet even with a non-empty FIFO.
    tick();
    @(negedge clk);
    check("rst_pop", {31'd0, bus.pop}, 32'd0);
    check("rst_outValid", {31'd0, bus.outValid}, 32'd0);
    check("rst_outData", {24'd0, bus.outData}, 32'h00);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    fq.delete();
    set_empty();

    // Basic ordering and latency.
    load(8'h05, 1'b1); load(8'h04, 1'b1); load(8'h03, 1'b1);
    tick();
    first_pop = -1; first_out = -1; last_out = -1; pop_cnt = 0;
    rst = 1'b1;
    c0 = cyc;
    repeat (5) tick();
    @(negedge clk);
    check("basic_first_pop_cycle", first_pop - c0, 0);
    check("basic_pop_count", pop_cnt, 3);
    check("basic_latency", first_out - first_pop, 2);
    check("basic_last_out", last_out - c0, 4);
    check("basic_busy_low", {31'd0, bus.busy}, 32'd0);
    check("basic_sb_empty", exp_q.size(), 0);

    // Backpressure: only two pops, head word held.
    tick();
    bus.outReady = 1'b0;
    pop_cnt = 0; d0 = deq_cnt;
    for (int i = 0; i < 8; i++) load(8'h10 + i[7:0], 1'b1);
    repeat (10) tick();
    @(negedge clk);
    check("bp_pop_count", pop_cnt, 2);
    check("bp_occ", {30'd0, dut.r_occ}, 32'd2);
    check("bp_outData_held", {24'd0, bus.outData}, 32'h10);
    check("bp_outValid", {31'd0, bus.outValid}, 32'd1);
    tick();
    bus.outReady = 1'b1;
    wait_drain("bp", 50);
    check("bp_words_delivered", deq_cnt - d0, 8);

    // Empty toggled every other cycle.
    tick();
    for (int i = 0; i < 6; i++) load(8'h30 + i[7:0], 1'b1);
    for (int i = 0; i < 20; i++) begin
      force_empty = i[0];
      set_empty();
      tick();
    end
    force_empty = 1'b0;
    set_empty();
    wait_drain("empty_toggle", 50);

    // Enable dropped while a word is in flight.
    tick();
    bus.en = 1'b0;
    load(8'h20, 1'b1);
    for (int i = 1; i < 4; i++) load(8'h20 + i[7:0], 1'b0);
    tick();
    p0 = pop_cnt; d0 = deq_cnt;
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("en_pop_count", pop_cnt - p0, 1);
    check("en_inflight_delivered", deq_cnt - d0, 1);
    check("en_sb_empty", exp_q.size(), 0);
    for (int i = 1; i < 4; i++) exp_q.push_back(8'h20 + i[7:0]);
    tick();
    bus.en = 1'b1;
    wait_drain("en", 50);

    // Mid-stream reset with a full buffer.
    tick();
    bus.outReady = 1'b0;
    for (int i = 0; i < 6; i++) load(8'hA0 + i[7:0], 1'b0);
    repeat (5) tick();
    check("mrst_occ_before", {30'd0, dut.r_occ}, 32'd2);
    rst = 1'b0;
    #1;
    check("mrst_outValid", {31'd0, bus.outValid}, 32'd0);
    check("mrst_outData", {24'd0, bus.outData}, 32'h00);
    check("mrst_busy", {31'd0, bus.busy}, 32'd0);
    check("mrst_pop", {31'd0, bus.pop}, 32'd0);
    for (int i = 2; i < 6; i++) exp_q.push_back(8'hA0 + i[7:0]);
    tick();
    rst = 1'b1;
    bus.outReady = 1'b1;
    wait_drain("mrst", 50);

`ifdef FIFO_POP_READER_CNT_EN
    tick();
    bus.clrCnt = 1'b1;
    tick();
    bus.clrCnt = 1'b0;
    for (int i = 0; i < 5; i++) load(8'h50 + i[7:0], 1'b1);
    wait_drain("cnt5", 50);
    check("cnt_five", {16'd0, bus.wordCnt}, 32'd5);

    tick();
    bus.outReady = 1'b0;
    for (int i = 0; i < 3; i++) load(8'h60 + i[7:0], 1'b1);
    repeat (5) tick();
    bus.outReady = 1'b1;
    bus.clrCnt = 1'b1;
    tick();
    bus.clrCnt = 1'b0;
    bus.outReady = 1'b0;
    @(negedge clk);
    check("cnt_clr_priority", {16'd0, bus.wordCnt}, 32'd0);
    bus.outReady = 1'b1;
    wait_drain("cnt_clr", 50);

    tick();
    bus.clrCnt = 1'b1;
    tick();
    bus.clrCnt = 1'b0;
    for (int i = 0; i < 65537; i++) load(i[7:0], 1'b1);
    wait_drain("cnt_wrap", 70000);
    check("cnt_wrap", {16'd0, bus.wordCnt}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
